// File: rtl/proj_topk_stream_sorter.sv
// Streaming bottom-K sorter: retains the K smallest {signature, index} pairs of a set, then drains them ascending.
// Optional build macro PROJ_SORTER_DEDUP_EN drops elements whose signature already sits in a valid slot.
module proj_topk_stream_sorter #(
   parameter int INDICES_COUNT = 8,
   parameter int INDICE_LEN    = 16,
   parameter int SIGNATURE_LEN = 32,
   parameter int POSITION_LEN  = $clog2(INDICES_COUNT)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [SIGNATURE_LEN-1:0] in_signature,
   input  logic [INDICE_LEN-1:0]    in_index,
   input  logic                     in_last,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [SIGNATURE_LEN-1:0] out_signature,
   output logic [INDICE_LEN-1:0]    out_index,
   output logic                     out_last,
   output logic [POSITION_LEN:0]    fill_count
);

   localparam logic [POSITION_LEN:0] K_CNT = (POSITION_LEN+1)'(INDICES_COUNT);
   localparam logic [POSITION_LEN:0] ONE   = (POSITION_LEN+1)'(1);

   typedef enum logic {COLLECT, DRAIN} state_t;

   state_t                   r_state, w_state_nxt;

   logic                     r_vld_p1, r_last_p1;
   logic [SIGNATURE_LEN-1:0] r_sig_p1;
   logic [INDICE_LEN-1:0]    r_idx_p1;

   logic [INDICES_COUNT-1:0] r_tbl_vld;
   logic [SIGNATURE_LEN-1:0] r_tbl_sig [INDICES_COUNT];
   logic [INDICE_LEN-1:0]    r_tbl_idx [INDICES_COUNT];
   logic [POSITION_LEN:0]    r_fill, r_rd_ptr;

   logic                     w_in_fire, w_out_fire, w_out_valid, w_out_last;
   logic                     w_drop, w_ins;
   logic [POSITION_LEN:0]    w_pos;
   logic [POSITION_LEN-1:0]  w_rd_slot;
   logic [INDICES_COUNT-1:0] w_nxt_vld;
   logic [SIGNATURE_LEN-1:0] w_nxt_sig [INDICES_COUNT];
   logic [INDICE_LEN-1:0]    w_nxt_idx [INDICES_COUNT];

   function automatic logic [POSITION_LEN:0] sat_inc(input logic [POSITION_LEN:0] v);
      return (v == K_CNT) ? v : v + ONE;
   endfunction

   assign in_ready   = (r_state == COLLECT) && !(r_vld_p1 && r_last_p1);
   assign w_in_fire  = in_valid && in_ready;

   // Stage p1 -> table: rank the staged element among valid slots (ties stay stable)
   always_comb begin
      w_pos = '0;
      for (int i = 0; i < INDICES_COUNT; i++) begin
         if (r_tbl_vld[i] && (r_tbl_sig[i] <= r_sig_p1)) w_pos = w_pos + ONE;
      end
   end

`ifdef PROJ_SORTER_DEDUP_EN
   logic w_dup;
   always_comb begin
      w_dup = 1'b0;
      for (int i = 0; i < INDICES_COUNT; i++) begin
         if (r_tbl_vld[i] && (r_tbl_sig[i] == r_sig_p1)) w_dup = 1'b1;
      end
   end
   assign w_drop = (w_pos == K_CNT) || w_dup;
`else
   assign w_drop = (w_pos == K_CNT);
`endif

   assign w_ins = r_vld_p1 && !w_drop;

   always_comb begin
      w_nxt_vld = r_tbl_vld;
      for (int i = 0; i < INDICES_COUNT; i++) begin
         w_nxt_sig[i] = r_tbl_sig[i];
         w_nxt_idx[i] = r_tbl_idx[i];
      end
      for (int i = 1; i < INDICES_COUNT; i++) begin
         if (i > int'(w_pos)) begin
            w_nxt_sig[i] = r_tbl_sig[i-1];
            w_nxt_idx[i] = r_tbl_idx[i-1];
            w_nxt_vld[i] = r_tbl_vld[i-1];
         end
      end
      for (int i = 0; i < INDICES_COUNT; i++) begin
         if (i == int'(w_pos)) begin
            w_nxt_sig[i] = r_sig_p1;
            w_nxt_idx[i] = r_idx_p1;
            w_nxt_vld[i] = 1'b1;
         end
      end
   end

   assign w_out_valid = (r_state == DRAIN) && (r_rd_ptr < r_fill);
   assign w_out_last  = w_out_valid && (r_rd_ptr == r_fill - ONE);
   assign w_out_fire  = w_out_valid && out_ready;
   assign w_rd_slot   = r_rd_ptr[POSITION_LEN-1:0];

   assign out_valid     = w_out_valid;
   assign out_last      = w_out_last;
   assign out_signature = w_out_valid ? r_tbl_sig[w_rd_slot] : '0;
   assign out_index     = w_out_valid ? r_tbl_idx[w_rd_slot] : '0;
   assign fill_count    = r_fill;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= COLLECT;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         COLLECT: if (r_vld_p1 && r_last_p1)        w_state_nxt = DRAIN;
         DRAIN:   if (w_out_fire && w_out_last)     w_state_nxt = COLLECT;
         default:                                   w_state_nxt = COLLECT;
      endcase
   end

   // Input -> stage p1 and table payload: data only, no reset needed
   always_ff @(posedge clk) begin
      if (w_in_fire) begin
         r_sig_p1 <= in_signature;
         r_idx_p1 <= in_index;
      end
      if (w_ins) begin
         for (int i = 0; i < INDICES_COUNT; i++) begin
            r_tbl_sig[i] <= w_nxt_sig[i];
            r_tbl_idx[i] <= w_nxt_idx[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_vld_p1  <= 1'b0;
         r_last_p1 <= 1'b0;
         r_tbl_vld <= '0;
         r_fill    <= '0;
         r_rd_ptr  <= '0;
      end else begin
         r_vld_p1  <= w_in_fire;
         r_last_p1 <= w_in_fire && in_last;
         if (w_out_fire && w_out_last) begin
            r_tbl_vld <= '0;
            r_fill    <= '0;
            r_rd_ptr  <= '0;
         end else begin
            if (w_out_fire) r_rd_ptr <= r_rd_ptr + ONE;
            if (w_ins) begin
               r_tbl_vld <= w_nxt_vld;
               r_fill    <= sat_inc(r_fill);
            end
         end
      end
   end

endmodule

// File: tb/tb_proj_topk_stream_sorter.sv
// Bench for proj_topk_stream_sorter (K=4): reference keeps the whole set, sorts it stably and keeps the first K.
module tb_proj_topk_stream_sorter;
   localparam int K  = 4;
   localparam int PL = $clog2(K);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
   logic [31:0]   in_signature = '0;
   logic [15:0]   in_index = '0;
   logic          in_ready, out_valid, out_last;
   logic [31:0]   out_signature;
   logic [15:0]   out_index;
   logic [PL:0]   fill_count;

   int checks = 0;
   int errors = 0;

   typedef struct packed {logic [31:0] sig; logic [15:0] idx;} ent_t;
   ent_t set_q[$];
   ent_t exp_q[$];

   always #5 clk = ~clk;

   proj_topk_stream_sorter #(.INDICES_COUNT(K), .INDICE_LEN(16), .SIGNATURE_LEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_signature(in_signature), .in_index(in_index), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_signature(out_signature),
      .out_index(out_index), .out_last(out_last), .fill_count(fill_count));

   initial begin
      #400000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

   // Expected result: (optionally de-duplicated) set, stable ascending by signature, first K kept
   function automatic void build_model();
      ent_t uniq[$];
      exp_q.delete();
      foreach (set_q[i]) begin
         bit dup = 1'b0;
`ifdef PROJ_SORTER_DEDUP_EN
         foreach (uniq[j]) if (uniq[j].sig == set_q[i].sig) dup = 1'b1;
`endif
         if (!dup) uniq.push_back(set_q[i]);
      end
      while (uniq.size() > 0 && exp_q.size() < K) begin
         int best = 0;
         for (int j = 1; j < uniq.size(); j++) if (uniq[j].sig < uniq[best].sig) best = j;
         exp_q.push_back(uniq[best]);
         uniq.delete(best);
      end
   endfunction

   task automatic push(input logic [31:0] s, input logic [15:0] ix, input logic l);
      int t = 0;
      set_q.push_back('{sig: s, idx: ix});
      in_valid = 1'b1; in_signature = s; in_index = ix; in_last = l;
      while (in_ready !== 1'b1 && t < 50) begin
         @(posedge clk); #1; t++;
      end
      checks++;
      if (t >= 50) begin
         errors++;
         $display("FAIL push_timeout in_ready=%b required 1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   // mode 0: always ready, 1: fixed stall pattern, 2: random ready. n_take<0 drains the whole set.
   task automatic drain(input int n_take, input int mode);
      int k = 0, t = 0, cyc = 0, n;
      logic rdy;
      bit stalled = 1'b0;
      logic [31:0] hs;
      logic [15:0] hi;
      logic hl;
      bit pat [7] = '{1, 0, 0, 1, 1, 0, 1};
      build_model();
      n = (n_take < 0) ? exp_q.size() : n_take;
      checks++;
      if (out_valid !== 1'b0) begin
         errors++; $display("FAIL drain_early out_valid=%b required 0", out_valid);
      end
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1) begin
         errors++; $display("FAIL drain_latency out_valid=%b required 1", out_valid);
      end
      checks++;
      if (fill_count !== exp_q.size()) begin
         errors++; $display("FAIL fill_before_drain fill_count=%0d required %0d", fill_count, exp_q.size());
      end
      while (k < n && t < 200) begin
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 7] : 1'($urandom_range(0, 1));
         in_valid = 1'($urandom_range(0, 1)); in_signature = $urandom;
         in_index = 16'($urandom); in_last = 1'($urandom_range(0, 1));
         checks++;
         if (in_ready !== 1'b0) begin
            errors++; $display("FAIL in_ready_in_drain in_ready=%b required 0", in_ready);
         end
         if (stalled) begin
            checks++;
            if (out_valid !== 1'b1 || out_signature !== hs || out_index !== hi || out_last !== hl) begin
               errors++;
               $display("FAIL stall_hold got v=%b sig=%0h idx=%0d last=%b required v=1 sig=%0h idx=%0d last=%b",
                        out_valid, out_signature, out_index, out_last, hs, hi, hl);
            end
         end
         checks++;
         if (out_valid !== 1'b1) begin
            errors++; $display("FAIL out_valid_in_drain out_valid=%b required 1 (entry %0d)", out_valid, k);
         end
         if (out_valid === 1'b1 && rdy) begin
            checks++;
            if (out_signature !== exp_q[k].sig || out_index !== exp_q[k].idx ||
                out_last !== ((k == exp_q.size() - 1) ? 1'b1 : 1'b0)) begin
               errors++;
               $display("FAIL entry%0d got sig=%0h idx=%0d last=%b required sig=%0h idx=%0d last=%b", k,
                        out_signature, out_index, out_last, exp_q[k].sig, exp_q[k].idx, (k == exp_q.size() - 1));
            end
            k++;
         end
         stalled = (out_valid === 1'b1) && !rdy;
         hs = out_signature; hi = out_index; hl = out_last;
         out_ready = rdy;
         @(posedge clk); #1;
         cyc++; t++;
      end
      out_ready = 1'b0; in_valid = 1'b0; in_last = 1'b0;
      if (t >= 200) begin
         checks++; errors++;
         $display("FAIL drain_timeout took=%0d required %0d", k, n);
      end
      if (n == exp_q.size()) begin
         checks++;
         if (out_valid !== 1'b0 || in_ready !== 1'b1 || fill_count !== '0) begin
            errors++;
            $display("FAIL after_drain out_valid=%b in_ready=%b fill=%0d required 0 1 0", out_valid, in_ready, fill_count);
         end
      end
      set_q.delete();
   endtask

   task automatic test_reset();
      rst_n = 1'b0; in_valid = 1'b1; in_signature = 32'h1234; in_index = 16'h7; in_last = 1'b1;
      idle(2);
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0) begin
         errors++; $display("FAIL reset_ctrl in_ready=%b out_valid=%b out_last=%b required 1 0 0", in_ready, out_valid, out_last);
      end
      checks++;
      if (out_signature !== '0 || out_index !== '0 || fill_count !== '0) begin
         errors++; $display("FAIL reset_data sig=%0h idx=%0h fill=%0d required 0 0 0", out_signature, out_index, fill_count);
      end
      in_valid = 1'b0; in_last = 1'b0; rst_n = 1'b1;
      idle(2);
      checks++;
      if (fill_count !== '0 || out_valid !== 1'b0) begin
         errors++; $display("FAIL reset_ignores_input fill=%0d out_valid=%b required 0 0", fill_count, out_valid);
      end
   endtask

   task automatic test_sorted();
      push(50, 0, 0); push(10, 1, 0); push(40, 2, 0); push(30, 3, 0); push(20, 4, 1);
      drain(-1, 0);
   endtask

   task automatic test_two();
      push(7, 9, 0); push(3, 5, 1);
      drain(-1, 0);
   endtask

   task automatic test_ties();
      push(5, 0, 0); push(5, 1, 0); push(5, 2, 1);
      drain(-1, 0);
   endtask

   task automatic test_full_drop();
      push(1, 0, 0); push(2, 1, 0); push(3, 2, 0); push(4, 3, 0); push(32'hFFFF_FFFF, 4, 1);
      drain(-1, 0);
      push(32'hFFFF_FFFF, 8, 0); push(6, 9, 1);
      drain(-1, 0);
   endtask

   task automatic test_stall();
      push(300, 1, 0); push(100, 2, 0); push(400, 3, 0); push(200, 4, 1);
      drain(-1, 1);
   endtask

   task automatic test_reset_mid_drain();
      push(40, 0, 0); push(30, 1, 0); push(20, 2, 0); push(10, 3, 1);
      drain(2, 0);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      checks++;
      if (out_valid !== 1'b0 || fill_count !== '0 || in_ready !== 1'b1 || out_last !== 1'b0) begin
         errors++;
         $display("FAIL mid_drain_reset out_valid=%b fill=%0d in_ready=%b out_last=%b required 0 0 1 0",
                  out_valid, fill_count, in_ready, out_last);
      end
      push(9, 3, 1);
      drain(-1, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 6; i++) begin
         checks++;
         if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready elem%0d in_ready=%b required 1", i, in_ready);
         end
         push(32'($urandom_range(0, 20)), 16'(100 + i), 1'b0);
         if (i == 2) begin
            idle(1);
            build_model();
            checks++;
            if (fill_count !== exp_q.size()) begin
               errors++; $display("FAIL b2b_fill fill=%0d required %0d", fill_count, exp_q.size());
            end
         end
      end
      push(32'($urandom_range(0, 20)), 16'd200, 1'b1);
      drain(-1, 2);
   endtask

   task automatic test_random();
      for (int s = 0; s < 10; s++) begin
         int len = $urandom_range(1, 9);
         for (int e = 0; e < len; e++) begin
            logic [31:0] sg = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 15));
            push(sg, 16'($urandom), (e == len - 1) ? 1'b1 : 1'b0);
            if (e != len - 1) idle($urandom_range(0, 2));
         end
         drain(-1, 2);
         idle($urandom_range(0, 2));
      end
   endtask

   initial begin
      test_reset();
      test_sorted();
      test_two();
      test_ties();
      test_full_drop();
      test_stall();
      test_reset_mid_drain();
      test_back_to_back();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
